// File: rtl/encoder_pkg.sv
// Shared encoder definitions: scheduler states, default sizing and the stage index map.
// The encoder top-level uses the same stage indices when it wires up the stage controllers.
package encoder_pkg;

    localparam int NUM_STAGES_DEF = 5;
    localparam int NUM_ROUNDS_DEF = 24;
    localparam int ACK_TO_DEF     = 4;

    localparam int STAGE_ABSORB = 0;
    localparam int STAGE_THETA  = 1;
    localparam int STAGE_ROTATE = 2;
    localparam int STAGE_CHI    = 3;
    localparam int STAGE_IOTA   = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_ADVANCE,
        S_FINISH,
        S_ERROR
    } sched_state_t;

    // Index width that stays at least one bit for single-entry counts.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sched_ack_timer.sv
// Acknowledge timer: counts cycles since a stage launch and flags when the stage
// has kept Ready high for ACK_TO cycles without acknowledging.
module sched_ack_timer
    import encoder_pkg::*;
#(
    parameter int  ACK_TO = ACK_TO_DEF,
    localparam int CW     = $clog2(ACK_TO + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          load,
    input  logic [CW-1:0] load_value,
    input  logic          en,
    output logic          expire
);

    logic [CW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (en && (count != CW'(ACK_TO))) begin
            count <= count + 1'b1;
        end
    end

    // Count reaches ACK_TO on the following edge, which is the cycle Error is entered.
    assign expire = en && (count == CW'(ACK_TO - 1));

endmodule

// File: rtl/encoder_scheduler.sv
// Encoder sequencer: launches each stage controller in order for NUM_ROUNDS rounds,
// grants the shared memory port to the active stage and exports round/stage indices.
module encoder_scheduler
    import encoder_pkg::*;
#(
    parameter int  NUM_STAGES = NUM_STAGES_DEF,
    parameter int  NUM_ROUNDS = NUM_ROUNDS_DEF,
    parameter int  ACK_TO     = ACK_TO_DEF,
    localparam int SW         = idx_width(NUM_STAGES),
    localparam int RW         = idx_width(NUM_ROUNDS),
    localparam int TW         = $clog2(ACK_TO + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  Ready,
    output logic                  done,
    output logic                  err,
    output logic [NUM_STAGES-1:0] stage_start,
    input  logic [NUM_STAGES-1:0] stage_ready,
    output logic [NUM_STAGES-1:0] mem_sel,
    output logic [RW-1:0]         round,
    output logic [SW-1:0]         stage
);

    sched_state_t          state, state_next;
    logic [NUM_STAGES-1:0] stage_onehot;
    logic                  sel_ready;
    logic                  last_stage, last_round;
    logic                  timer_load, timer_expire;
    logic                  begin_encode;

    assign stage_onehot = NUM_STAGES'(1) << stage;
    assign sel_ready    = stage_ready[stage];
    assign last_stage   = (stage == SW'(NUM_STAGES - 1));
    assign last_round   = (round == RW'(NUM_ROUNDS - 1));
    assign begin_encode = start && ((state == S_IDLE) || (state == S_ERROR));

    sched_ack_timer #(.ACK_TO(ACK_TO)) u_ack_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (state == S_IDLE),
        .load       (timer_load),
        .load_value (TW'(1)),
        .en         (state == S_WAIT_ACK),
        .expire     (timer_expire)
    );

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next  = state;
        stage_start = '0;
        mem_sel     = '0;
        timer_load  = 1'b0;
        unique case (state)
            S_IDLE, S_ERROR: begin
                if (start) state_next = S_LAUNCH;
            end
            S_LAUNCH: begin
                mem_sel = stage_onehot;
                if (sel_ready) begin
                    stage_start = stage_onehot;
                    timer_load  = 1'b1;
                    state_next  = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                mem_sel = stage_onehot;
                if (!sel_ready)       state_next = S_WAIT_DONE;
                else if (timer_expire) state_next = S_ERROR;
            end
            S_WAIT_DONE: begin
                mem_sel = stage_onehot;
                if (sel_ready) state_next = S_ADVANCE;
            end
            S_ADVANCE: begin
                state_next = (last_stage && last_round) ? S_FINISH : S_LAUNCH;
            end
            S_FINISH: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            round <= '0;
            stage <= '0;
        end else begin
            state <= state_next;
            if (begin_encode) begin
                round <= '0;
                stage <= '0;
            end else if (state == S_ADVANCE) begin
                if (!last_stage) begin
                    stage <= stage + 1'b1;
                end else if (!last_round) begin
                    round <= round + 1'b1;
                    stage <= '0;
                end
            end
        end
    end

    assign Ready = (state == S_IDLE);
    assign done  = (state == S_FINISH);
    assign err   = (state == S_ERROR);

endmodule

// File: tb/tb_encoder_scheduler.sv
// Directed bench for encoder_scheduler: stage controllers are modelled as Ready
// dropping for L cycles after each launch, with per-stage stall and no-ack knobs.
module tb_encoder_scheduler;
    import encoder_pkg::*;

    localparam int NS = 5;
    localparam int NR = 2;
    localparam int AT = 4;
    localparam int L  = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          Ready, done, err;
    logic [NS-1:0] stage_start, stage_ready, mem_sel;
    logic [0:0]    round;
    logic [2:0]    stage;

    logic [NS-1:0] force_low;
    logic [NS-1:0] no_ack;
    int            busy [NS];

    int checks = 0;
    int errors = 0;

    int pulse_stage [32];
    int pulse_round [32];

    always #5 clk = ~clk;

    encoder_scheduler #(
        .NUM_STAGES (NS),
        .NUM_ROUNDS (NR),
        .ACK_TO     (AT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .Ready       (Ready),
        .done        (done),
        .err         (err),
        .stage_start (stage_start),
        .stage_ready (stage_ready),
        .mem_sel     (mem_sel),
        .round       (round),
        .stage       (stage)
    );

    // Stage controller model: a launch drops Ready for L cycles starting next cycle.
    always @(posedge clk or negedge reset) begin
        for (int i = 0; i < NS; i++) begin
            if (!reset)                         busy[i] <= 0;
            else if (stage_start[i] && !no_ack[i]) busy[i] <= L;
            else if (busy[i] > 0)               busy[i] <= busy[i] - 1;
        end
    end

    always_comb begin
        stage_ready = '0;
        for (int i = 0; i < NS; i++) stage_ready[i] = (busy[i] == 0) && !force_low[i];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [NS-1:0] v);
        if ($countones(v) != 1) return -1;
        for (int i = 0; i < NS; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Leaves start high and returns just after the sampling edge.
    task automatic start_edge();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
    endtask

    // One-cycle start; returns at the negedge of the first Launch cycle.
    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic observe_encode(input bit hold, output int done_n, output int npulse,
                                  output int ready_err);
        done_n = 0; npulse = 0; ready_err = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (!hold) start = 1'b0;
            if (stage_start != '0) begin
                if (npulse < 32) begin
                    pulse_stage[npulse] = onehot_idx(stage_start);
                    pulse_round[npulse] = int'(round);
                end
                if (mem_sel != stage_start) ready_err++;
                npulse++;
            end
            if (Ready) ready_err++;
            if (done) begin
                done_n = n;
                break;
            end
        end
    endtask

    task automatic wait_pulse(input int idx, input int rnd, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (stage_start[idx] && (int'(round) == rnd)) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("done_timeout", 32'(seen), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int done_n, npulse, ready_err;
        bit ok;

        reset = 1'b0; start = 1'b0; force_low = '0; no_ack = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(Ready), 1);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        check("rst_stage_start", 32'(stage_start), 0);
        check("rst_mem_sel", 32'(mem_sel), 0);
        check("rst_round", 32'(round), 0);
        check("rst_stage", 32'(stage), 0);
        reset = 1'b1;
        @(negedge clk);

        // Full encode: 2 rounds x 5 stages at L=3 -> done 1 + 10*6 cycles after start.
        start_edge();
        observe_encode(1'b0, done_n, npulse, ready_err);
        check("full_npulse", npulse, 10);
        for (int i = 0; i < 10 && i < npulse; i++) begin
            check($sformatf("full_pulse_stage%0d", i), pulse_stage[i], i % NS);
            check($sformatf("full_pulse_round%0d", i), pulse_round[i], i / NS);
        end
        check("full_done_cycle", done_n, 61);
        check("full_ready_low_memsel", ready_err, 0);
        @(negedge clk);
        check("full_ready_back", 32'(Ready), 1);
        check("full_done_single", 32'(done), 0);

        // Rotate stage not Ready when its turn comes: wait in Launch without a pulse.
        force_low[STAGE_ROTATE] = 1'b1;
        start_pulse();
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (mem_sel == 5'b00100) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        check("stall_reached", 32'(ok), 1);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("stall_no_pulse%0d", k), 32'(stage_start), 0);
            check($sformatf("stall_mem_sel%0d", k), 32'(mem_sel), 32'h4);
        end
        @(negedge clk);
        force_low[STAGE_ROTATE] = 1'b0;
        #1;
        check("stall_pulse", 32'(stage_start), 32'h4);
        @(negedge clk);
        check("stall_pulse_once", 32'(stage_start), 0);
        check("stall_wait_ack_sel", 32'(mem_sel), 32'h4);
        wait_done();

        // Stage that never drops Ready: Error ACK_TO cycles after its pulse.
        no_ack[STAGE_THETA] = 1'b1;
        start_pulse();
        wait_pulse(STAGE_THETA, 0, ok);
        check("ackto_pulse_seen", 32'(ok), 1);
        for (int k = 1; k < AT; k++) begin
            @(negedge clk);
            check($sformatf("ackto_no_err%0d", k), 32'(err), 0);
            check($sformatf("ackto_sel%0d", k), 32'(mem_sel), 32'h2);
        end
        @(negedge clk);
        check("ackto_err", 32'(err), 1);
        check("ackto_mem_sel", 32'(mem_sel), 0);
        check("ackto_ready", 32'(Ready), 0);
        @(negedge clk);
        check("ackto_err_hold", 32'(err), 1);
        no_ack[STAGE_THETA] = 1'b0;
        start_pulse();
        #1;
        check("restart_err_clear", 32'(err), 0);
        check("restart_stage", 32'(stage), STAGE_ABSORB);
        check("restart_round", 32'(round), 0);
        check("restart_pulse", 32'(stage_start), 32'h1);
        wait_done();

        // Asynchronous reset in WaitDone of round 1, stage 3.
        start_pulse();
        wait_pulse(STAGE_CHI, 1, ok);
        check("arst_pulse_seen", 32'(ok), 1);
        repeat (2) @(negedge clk);
        check("arst_pre_sel", 32'(mem_sel), 32'h8);
        check("arst_pre_round", 32'(round), 1);
        #3;
        reset = 1'b0;
        #1;
        check("arst_ready", 32'(Ready), 1);
        check("arst_mem_sel", 32'(mem_sel), 0);
        check("arst_round", 32'(round), 0);
        check("arst_stage", 32'(stage), 0);
        check("arst_err", 32'(err), 0);
        check("arst_start", 32'(stage_start), 0);
        @(negedge clk);
        reset = 1'b1;
        start_pulse();
        #1;
        check("arst_restart_round", 32'(round), 0);
        check("arst_restart_pulse", 32'(stage_start), 32'h1);
        wait_done();

        // start held high for a whole encode: no extra launches, one done, relaunch from Idle.
        start_edge();
        observe_encode(1'b1, done_n, npulse, ready_err);
        check("held_npulse", npulse, 10);
        check("held_done_cycle", done_n, 61);
        check("held_ready_low_memsel", ready_err, 0);
        @(negedge clk);
        check("held_idle_ready", 32'(Ready), 1);
        check("held_idle_no_pulse", 32'(stage_start), 0);
        check("held_idle_no_done", 32'(done), 0);
        @(negedge clk);
        check("held_relaunch_ready", 32'(Ready), 0);
        check("held_relaunch_pulse", 32'(stage_start), 32'h1);
        check("held_relaunch_round", 32'(round), 0);
        start = 1'b0;
        wait_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
